stack_calc_ctrl: RTL
====================

# stack_calc_ctrl

Command sequencer for the stackcalc design: takes operator commands from the TinyTapeout input pins and sequences a small register-file stack and a 6-bit adder/subtractor through a multi-cycle FSM. Top-of-stack, busy and error status are presented on the output pins. The block sits at the top level in place of the free-running step counter and owns every access to the stack storage.

## Interface
- DEPTH, 4: stack entries, 2..8
- WIDTH, 6: data width; fixed by the io_out packing
- io_in[0]  in  1  clk; all state on its rising edge
- io_in[1]  in  1  rst; asynchronous, active-high
- io_in[2]  in  1  strobe; asynchronous to clk, command issued on its rising edge
- io_in[4:3]  in  2  op: 00 PUSH, 01 ADD, 10 SUB, 11 MISC
- io_in[7:5]  in  3  arg: PUSH immediate (zero-extended) or MISC sub-op
- io_out[5:0]  out  6  top-of-stack value; 0 when the stack is empty
- io_out[6]  out  1  busy
- io_out[7]  out  1  err, sticky

## Operation
- Strobe path: 2-FF synchronizer plus a history flop. edge = sync2 & ~hist. op and arg are sampled raw on the edge cycle and must be stable from the strobe rise until busy falls.
- FSM states: IDLE, POP_B, POP_A, EXEC, PUSH.
- IDLE + edge, PUSH: latch the immediate, go to PUSH.
- IDLE + edge, ADD/SUB: go to POP_B.
- IDLE + edge, MISC: handled per sub-op below.
- POP_B: b ← mem[sp-1], sp−1, go to POP_A.
- POP_A: a ← mem[sp-1], sp−1, go to EXEC.
- EXEC: r ← a+b or a−b, mod 2^WIDTH, no carry or borrow kept. Go to PUSH.
- PUSH: mem[sp] ← r, sp+1, go to IDLE.
- MISC sub-ops:
  - 000 DROP: sp−1.
  - 001 DUP: r ← tos, then PUSH.
  - 010 SWAP: POP_B, POP_A, then two PUSH cycles writing b then a.
  - 011 CLR: sp ← 0, err ← 0.
  - others: NOP.
- DROP, CLR and NOP complete in IDLE in one cycle, with busy never asserted.
- Error checks happen in IDLE, before any state change:
  - underflow: ADD, SUB or SWAP with sp<2, or DROP or DUP with sp=0.
  - overflow: PUSH or DUP with sp=DEPTH.
  - On either, set err, leave the stack and sp untouched, stay in IDLE.
- err clears only on CLR or reset.
- Stack pointer sp is $clog2(DEPTH+1) bits, range 0..DEPTH. It never wraps: the checks above forbid it.
- tos register tracks mem[sp-1] after every write or pop, and is 0 when sp=0.
- busy = (state != IDLE).

## Timing
- Reset: async, everything returns to IDLE immediately.
  - io_out = 0x00, sp = 0, err = 0, sync flops = 0.
  - Reset during any state aborts the operation; no partial write survives.
- Edge latency: if strobe is first sampled high at clk edge N, the edge pulse is high in cycle N+2 (one cycle).
- Command latency, counted from the edge cycle E:
  - PUSH: busy high in E+1, tos updated and busy low at E+2.
  - ADD, SUB: busy high E+1..E+4, result on io_out at E+5.
  - DUP: busy high in E+1, tos valid at E+2.
  - SWAP: busy high E+1..E+4, tos valid at E+5.
- Edges arriving while busy are dropped; nothing is queued.
- A held strobe produces exactly one edge.

## Structure
- Shared package stackcalc_pkg holds:
  - opcode and MISC sub-op localparams;
  - state encoding;
  - io_out bit positions (ERR_BIT=7, BUSY_BIT=6).
- Sub-module stack_regfile: DEPTH×WIDTH registers, one synchronous write port, one combinational read port, no reset on contents.
- Controller, synchronizer and ALU live in stack_calc_ctrl.

## Test plan
- Reset: assert rst mid-ADD (state POP_A) → io_out=0x00 asynchronously; after release, a PUSH 1 gives io_out=0x01.
- Add: PUSH 3, PUSH 5, ADD → io_out=0x08. Busy high exactly 4 cycles; result appears 5 cycles after the edge.
- Wrap: PUSH 2, PUSH 5, SUB → 0x3D (61). Then PUSH 7, ADD → 0x04, no err.
- Overflow: DEPTH=4, PUSH 1,2,3,4 then PUSH 5 → io_out=0x84 (err set, tos still 4). CLR → 0x00.
- Underflow: CLR, PUSH 6, ADD → 0x86 (err set, stack unchanged). SWAP on 2 entries (1, 6) → tos=1.
- Busy drop: issue ADD, pulse strobe again during busy with PUSH 7 → ignored, sp unchanged, result as in the Add test.

Source files
------------

// File: rtl/stackcalc_pkg.sv
// Shared definitions for the stackcalc design: opcodes, MISC sub-ops,
// controller state encoding and io_out bit positions.
package stackcalc_pkg;

    // Primary opcodes (io_in[4:3])
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MISC = 2'b11;

    // MISC sub-ops (io_in[7:5] when op is MISC)
    localparam logic [2:0] MISC_DROP = 3'b000;
    localparam logic [2:0] MISC_DUP  = 3'b001;
    localparam logic [2:0] MISC_SWAP = 3'b010;
    localparam logic [2:0] MISC_CLR  = 3'b011;

    // Status bit positions on io_out
    localparam int ERR_BIT  = 7;
    localparam int BUSY_BIT = 6;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP_B = 3'd1,
        ST_POP_A = 3'd2,
        ST_EXEC  = 3'd3,
        ST_PUSH  = 3'd4
    } state_t;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x WIDTH registers, one synchronous write port and
// one combinational read port. Contents are not reset; the stack pointer
// in the controller defines which entries are meaningful.
module stack_regfile
    import stackcalc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_calc_ctrl.sv
// Command sequencer: synchronizes the strobe pin, decodes op/arg and walks
// the stack through pop/exec/push cycles. io_out = {err, busy, tos}.
module stack_calc_ctrl
    import stackcalc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int SP_W   = $clog2(DEPTH + 1);
    localparam int ADDR_W = $clog2(DEPTH);

    logic       clk;
    logic       rst;
    logic       strobe;
    logic [1:0] op;
    logic [2:0] arg;

    assign clk    = io_in[0];
    assign rst    = io_in[1];
    assign strobe = io_in[2];
    assign op     = io_in[4:3];
    assign arg    = io_in[7:5];

    logic            sync1_reg, sync2_reg, hist_reg;
    logic            edge_pulse;
    state_t          state_reg;
    logic [SP_W-1:0] sp_reg;
    logic [WIDTH-1:0] tos_reg, a_reg, b_reg, r_reg;
    logic            err_reg;
    logic            is_sub_reg;
    logic            swap_reg;

    logic [SP_W-1:0]   sp_m2;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              wr_en;
    logic              sp_ge2;
    logic [WIDTH-1:0]  below_tos;

    // Strobe synchronizer plus history flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= 1'b0;
        end else begin
            sync1_reg <= strobe;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign edge_pulse = sync2_reg & ~hist_reg;

    // The read port always looks at the entry under the top, so any pop can
    // refresh tos in the same cycle; the popped value itself is tos_reg.
    assign sp_m2     = sp_reg - SP_W'(2);
    assign rd_addr   = sp_m2[ADDR_W-1:0];
    assign sp_ge2    = (sp_reg >= SP_W'(2));
    assign below_tos = sp_ge2 ? rd_data : '0;
    assign wr_en     = (state_reg == ST_PUSH);

    stack_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (sp_reg[ADDR_W-1:0]),
        .wdata (r_reg),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Controller FSM: error checks and command dispatch in IDLE, then the
    // pop/exec/push sequence; pushes may repeat once for SWAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            sp_reg     <= '0;
            tos_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            r_reg      <= '0;
            err_reg    <= 1'b0;
            is_sub_reg <= 1'b0;
            swap_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (edge_pulse) begin
                        case (op)
                            OP_PUSH: begin
                                if (sp_reg == SP_W'(DEPTH)) begin
                                    err_reg <= 1'b1;
                                end else begin
                                    r_reg     <= {{(WIDTH-3){1'b0}}, arg};
                                    state_reg <= ST_PUSH;
                                end
                            end
                            OP_ADD, OP_SUB: begin
                                if (!sp_ge2) begin
                                    err_reg <= 1'b1;
                                end else begin
                                    is_sub_reg <= (op == OP_SUB);
                                    swap_reg   <= 1'b0;
                                    state_reg  <= ST_POP_B;
                                end
                            end
                            default: begin
                                case (arg)
                                    MISC_DROP: begin
                                        if (sp_reg == '0) begin
                                            err_reg <= 1'b1;
                                        end else begin
                                            sp_reg  <= sp_reg - SP_W'(1);
                                            tos_reg <= below_tos;
                                        end
                                    end
                                    MISC_DUP: begin
                                        if (sp_reg == '0 || sp_reg == SP_W'(DEPTH)) begin
                                            err_reg <= 1'b1;
                                        end else begin
                                            r_reg     <= tos_reg;
                                            state_reg <= ST_PUSH;
                                        end
                                    end
                                    MISC_SWAP: begin
                                        if (!sp_ge2) begin
                                            err_reg <= 1'b1;
                                        end else begin
                                            swap_reg  <= 1'b1;
                                            state_reg <= ST_POP_B;
                                        end
                                    end
                                    MISC_CLR: begin
                                        sp_reg  <= '0;
                                        tos_reg <= '0;
                                        err_reg <= 1'b0;
                                    end
                                    default: ;
                                endcase
                            end
                        endcase
                    end
                end
                ST_POP_B: begin
                    b_reg     <= tos_reg;
                    sp_reg    <= sp_reg - SP_W'(1);
                    tos_reg   <= below_tos;
                    state_reg <= ST_POP_A;
                end
                ST_POP_A: begin
                    a_reg   <= tos_reg;
                    sp_reg  <= sp_reg - SP_W'(1);
                    tos_reg <= below_tos;
                    if (swap_reg) begin
                        r_reg     <= b_reg;
                        state_reg <= ST_PUSH;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_reg     <= is_sub_reg ? (a_reg - b_reg) : (a_reg + b_reg);
                    state_reg <= ST_PUSH;
                end
                ST_PUSH: begin
                    sp_reg  <= sp_reg + SP_W'(1);
                    tos_reg <= r_reg;
                    if (swap_reg) begin
                        r_reg    <= a_reg;
                        swap_reg <= 1'b0;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign io_out[ERR_BIT]    = err_reg;
    assign io_out[BUSY_BIT]   = (state_reg != ST_IDLE);
    assign io_out[WIDTH-1:0]  = tos_reg;

endmodule
